score_digit_drawer: RTL and testbench

- Downstream consumer of the binary-to-BCD converter.
- Captures the four BCD score digits (thousands, hundreds, tens, ones) and renders them as 5x7 glyphs into the VGA pixel-plot interface.
- Emits one pixel per accepted handshake and pulses done when all four digits are drawn.
- Sits between the score converter and the VGA plot arbiter.

---
 rtl/score_draw_pkg.sv | 38 +++
 rtl/digit_font_rom.sv | 46 ++++
 rtl/score_digit_drawer.sv | 188 ++++++++++++++++++
 tb/tb_score_digit_drawer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_draw_pkg.sv
// Shared types and glyph geometry for the score digit drawer.
// Holds the draw FSM state type, the packed four-digit score record and
// the glyph/layout constants used by the drawer and its font ROM.
package score_draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int GLYPH_W     = 5;
    localparam int GLYPH_H     = 7;
    localparam int DIGIT_PITCH = 6;
    localparam int NUM_DIGITS  = 4;

    // Score as delivered by the converter: thousands is only 3 bits wide.
    typedef struct packed {
        logic [2:0] tho;
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
    } digits_t;

    // Digit value for screen position d (0 = thousands ... 3 = ones).
    function automatic logic [3:0] digit_at(input digits_t dg, input logic [1:0] d);
        logic [3:0] v;
        unique case (d)
            2'd0:    v = {1'b0, dg.tho};
            2'd1:    v = dg.hun;
            2'd2:    v = dg.ten;
            default: v = dg.one;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/digit_font_rom.sv
// 5x7 font for decimal digits 0-9.
// Purely combinational: returns whether the glyph pixel at (row, col) of the
// given digit value is lit. Values 10-15 and out-of-box coordinates read 0.
module digit_font_rom
    import score_draw_pkg::*;
(
    input  logic [3:0] value,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel_on
);

    // Row 0 occupies the top five bits; within a row, column 0 is the MSB.
    logic [34:0] glyph;
    logic [5:0]  idx;

    // Select the 35-bit bitmap of the requested digit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        glyph = '0;
        unique case (value)
            4'd0:    glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1:    glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: glyph = '0;
        endcase
    end

    // Pick the addressed bit; coordinates outside the 5x7 box read as off.
    always_comb begin
        idx      = {3'b000, row} * 6'(GLYPH_W) + {3'b000, col};
        pixel_on = 1'b0;
        if (row < 3'(GLYPH_H) && col < 3'(GLYPH_W)) begin
            pixel_on = glyph[6'd34 - idx];
        end
    end

endmodule

// File: rtl/score_digit_drawer.sv
// Score digit drawer: renders four BCD score digits as 5x7 glyphs into the
// VGA pixel-plot interface, one pixel per plot/ready handshake, and pulses
// done after the last of the 140 pixels is accepted.
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits among the
// thousands, hundreds and tens positions are drawn as background.
module score_digit_drawer
    import score_draw_pkg::*;
#(
    parameter int                  X_W      = 8,
    parameter int                  Y_W      = 7,
    parameter int                  COLOUR_W = 3,
    parameter logic [X_W-1:0]      X0       = 8'd4,
    parameter logic [Y_W-1:0]      Y0       = 7'd4,
    parameter logic [COLOUR_W-1:0] FG       = 3'b111,
    parameter logic [COLOUR_W-1:0] BG       = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          tho,
    input  logic [3:0]          hun,
    input  logic [3:0]          ten,
    input  logic [3:0]          one,
    input  logic                ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    state_t     state, state_next;
    logic       start_q;
    logic       trigger;
    digits_t    in_digits;
    digits_t    work;
    digits_t    shadow;
    logic       pending;
    logic [1:0] d;
    logic [2:0] r;
    logic [2:0] c;
    logic       last_pixel;
    logic       accept;
    logic [3:0] cur_val;
    logic       digit_blank;
    logic       glyph_on;

    assign in_digits  = '{tho: tho, hun: hun, ten: ten, one: one};
    assign trigger    = start & ~start_q;
    assign accept     = (state == DRAW) && ready;
    assign last_pixel = (d == 2'(NUM_DIGITS - 1)) &&
                        (r == 3'(GLYPH_H - 1)) &&
                        (c == 3'(GLYPH_W - 1));

    // Remember last cycle's start so only its rising edge triggers a draw.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) start_q <= 1'b0;
        else     start_q <= start;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a trigger seen in FIN chains straight into LOAD.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trigger) state_next = LOAD;
            LOAD:    state_next = DRAW;
            DRAW:    if (accept && last_pixel) state_next = FIN;
            FIN:     state_next = (pending || trigger) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working digits for the draw in progress plus the one-deep pending buffer.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these few digit registers are plain flops rather than a
        // memory, so they are cleared by reset along with the rest.
        if (rst) begin
            work    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) work <= in_digits;
                end
                LOAD, DRAW: begin
                    if (trigger) begin
                        shadow  <= in_digits;
                        pending <= 1'b1;
                    end
                end
                FIN: begin
                    if (trigger) begin
                        shadow  <= in_digits;
                        work    <= in_digits;
                        pending <= 1'b0;
                    end else if (pending) begin
                        work    <= shadow;
                        pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan position: column fastest, then row, then digit; moves on handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
            r <= '0;
            c <= '0;
        end else if (state == LOAD) begin
            d <= '0;
            r <= '0;
            c <= '0;
        end else if (accept) begin
            if (c == 3'(GLYPH_W - 1)) begin
                c <= '0;
                if (r == 3'(GLYPH_H - 1)) begin
                    r <= '0;
                    d <= d + 2'd1;
                end else begin
                    r <= r + 3'd1;
                end
            end else begin
                c <= c + 3'd1;
            end
        end
    end

    assign cur_val = digit_at(work, d);

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-2:0] lead_zero;

    // A position is a leading zero when it and everything to its left is 0.
    always_comb begin
        lead_zero[0] = (work.tho == 3'd0);
        lead_zero[1] = lead_zero[0] && (work.hun == 4'd0);
        lead_zero[2] = lead_zero[1] && (work.ten == 4'd0);
    end

    // Blank out-of-range thousands and leading zeros; ones always renders.
    always_comb begin
        digit_blank = (d == 2'd0) && (work.tho > 3'd4);
        if (d != 2'(NUM_DIGITS - 1) && lead_zero[d]) digit_blank = 1'b1;
    end
`else
    // Only a thousands value beyond 4 is forced blank in this build.
    always_comb begin
        digit_blank = (d == 2'd0) && (work.tho > 3'd4);
    end
`endif

    digit_font_rom u_font (
        .value    (cur_val),
        .row      (r),
        .col      (c),
        .pixel_on (glyph_on)
    );

    // Pixel interface and status outputs, decoded from state and scan position.
    always_comb begin
        x      = '0;
        y      = '0;
        colour = BG;
        plot   = 1'b0;
        busy   = (state == LOAD) || (state == DRAW);
        done   = (state == FIN);
        if (state == DRAW) begin
            plot   = 1'b1;
            x      = X0 + X_W'(DIGIT_PITCH) * X_W'(d) + X_W'(c);
            y      = Y0 + Y_W'(r);
            colour = (glyph_on && !digit_blank) ? FG : BG;
        end
    end

endmodule

// File: tb/tb_score_digit_drawer.sv
// Testbench for score_digit_drawer: scenario tasks drive start/ready and
// compare every accepted pixel against a reference model built from the
// digit layout rules and a string-based font table.
module tb_score_digit_drawer;

    localparam logic [7:0] X0 = 8'd4;
    localparam logic [6:0] Y0 = 7'd4;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] tho = '0;
    logic [3:0] hun = '0;
    logic [3:0] ten = '0;
    logic [3:0] one = '0;
    logic       ready = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Capture results: accepted pixels {x,y,colour}, their cycles, done cycles.
    logic [17:0] hs_pix[$];
    int          hs_cyc[$];
    int          done_cyc[$];
    int          stable_err;
    bit          rst_seen;
    logic        rst_plot, rst_busy, rst_done;

    score_digit_drawer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .tho    (tho),
        .hun    (hun),
        .ten    (ten),
        .one    (one),
        .ready  (ready),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    // Font drawn as text rows; '1' marks a lit pixel, leftmost char = column 0.
    function automatic string glyph_row(input int v, input int r);
        string g[7];
        case (v)
            0: g = '{"01110","10001","10011","10101","11001","10001","01110"};
            1: g = '{"00100","01100","00100","00100","00100","00100","01110"};
            2: g = '{"01110","10001","00001","00010","00100","01000","11111"};
            3: g = '{"11111","00010","00100","00010","00001","10001","01110"};
            4: g = '{"00010","00110","01010","10010","11111","00010","00010"};
            5: g = '{"11111","10000","11110","00001","00001","10001","01110"};
            6: g = '{"00110","01000","10000","11110","10001","10001","01110"};
            7: g = '{"11111","00001","00010","00100","01000","01000","01000"};
            8: g = '{"01110","10001","10001","01110","10001","10001","01110"};
            9: g = '{"01110","10001","10001","01111","00001","00010","01100"};
            default: g = '{"00000","00000","00000","00000","00000","00000","00000"};
        endcase
        return g[r];
    endfunction

    // Expected k-th pixel (0..139) of a draw of dig = {tho,hun,ten,one}.
    function automatic logic [17:0] exp_pixel(input logic [14:0] dig, input int k);
        int vals[4];
        int d, r, c, v;
        bit blank;
        string s;
        logic [7:0] xe;
        logic [6:0] ye;
        logic [2:0] ce;
        vals[0] = int'(dig[14:12]);
        vals[1] = int'(dig[11:8]);
        vals[2] = int'(dig[7:4]);
        vals[3] = int'(dig[3:0]);
        d = k / 35;
        r = (k % 35) / 5;
        c = k % 5;
        v = vals[d];
        blank = (v > 9) || (d == 0 && v > 4);
`ifdef LEADING_ZERO_BLANK_EN
        if (d < 3) begin
            bit allz;
            allz = 1'b1;
            for (int j = 0; j <= d; j++) if (vals[j] != 0) allz = 1'b0;
            if (allz) blank = 1'b1;
        end
`endif
        s  = glyph_row(v, r);
        ce = (!blank && s[c] == 8'h31) ? FG : BG;
        xe = 8'(int'(X0) + 6 * d + c);
        ye = 7'(int'(Y0) + r);
        return {xe, ye, ce};
    endfunction

    // Runs one bounded window starting with a start edge at cycle 0 and records
    // handshakes. Optional retrigger at a pixel count and reset at a pixel count.
    task automatic capture(input logic [14:0] dig, input int ncycles, input int ready_mode,
                           input int hold, input int retrig_pix, input logic [14:0] retrig_dig,
                           input int rst_pix);
        logic [17:0] cur, prev_pix;
        logic prev_wait;
        int retrig_clr;
        bit retrig_done;
        hs_pix.delete();
        hs_cyc.delete();
        done_cyc.delete();
        stable_err  = 0;
        rst_seen    = 1'b0;
        prev_wait   = 1'b0;
        prev_pix    = '0;
        retrig_clr  = -1;
        retrig_done = 1'b0;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge clk);
            cur = {x, y, colour};
            if (prev_wait && plot && cur !== prev_pix) stable_err++;
            if (done) done_cyc.push_back(i);
            if (i == 0) begin
                {tho, hun, ten, one} = dig;
                start = 1'b1;
            end
            if (i == hold || i == retrig_clr) start = 1'b0;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = (i % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_pix >= 0 && !rst_seen && plot && hs_pix.size() == rst_pix) begin
                rst = 1'b1;
                #1;
                rst_plot = plot;
                rst_busy = busy;
                rst_done = done;
                rst_seen = 1'b1;
                #1;
                rst = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (plot && ready) begin
                    hs_pix.push_back(cur);
                    hs_cyc.push_back(i);
                end
                prev_wait = plot && !ready;
                prev_pix  = cur;
                if (retrig_pix >= 0 && !retrig_done && hs_pix.size() == retrig_pix) begin
                    {tho, hun, ten, one} = retrig_dig;
                    start       = 1'b1;
                    retrig_done = 1'b1;
                    retrig_clr  = i + 1;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #10;
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (x !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (y !== 7'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
        checks++; if (colour !== BG) begin errors++; $display("FAIL reset_colour got %b want %b", colour, BG); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_start got plot=%b busy=%b want 0 0", plot, busy);
        end
    endtask

    task automatic test_basic();
        logic [14:0] dig = {3'd1, 4'd2, 4'd3, 4'd4};
        capture(dig, 160, 0, 1, -1, '0, -1);
        checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL basic_count got %0d want 140", hs_pix.size()); end
        for (int k = 0; k < hs_pix.size() && k < 140; k++) begin
            checks++;
            if (hs_pix[k] !== exp_pixel(dig, k)) begin
                errors++; $display("FAIL basic_pix[%0d] got %h want %h", k, hs_pix[k], exp_pixel(dig, k));
            end
        end
        if (hs_pix.size() == 140) begin
            checks++; if (hs_cyc[0] != 2) begin errors++; $display("FAIL basic_first_cycle got %0d want 2", hs_cyc[0]); end
            checks++; if (hs_cyc[139] != 141) begin errors++; $display("FAIL basic_last_cycle got %0d want 141", hs_cyc[139]); end
            checks++; if (hs_pix[0][17:3] !== {8'd4, 7'd4}) begin
                errors++; $display("FAIL basic_first_xy got %0d,%0d want 4,4", hs_pix[0][17:10], hs_pix[0][9:3]);
            end
            checks++; if (hs_pix[139][17:3] !== {8'd26, 7'd10}) begin
                errors++; $display("FAIL basic_last_xy got %0d,%0d want 26,10", hs_pix[139][17:10], hs_pix[139][9:3]);
            end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cyc.size()); end
        else begin
            checks++; if (done_cyc[0] != 142) begin errors++; $display("FAIL basic_done_cycle got %0d want 142", done_cyc[0]); end
        end
    endtask

    task automatic test_ready_toggle();
        logic [14:0] dig = {3'd1, 4'd2, 4'd3, 4'd4};
        capture(dig, 440, 1, 1, -1, '0, -1);
        checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL toggle_count got %0d want 140", hs_pix.size()); end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL toggle_stable got %0d changes want 0", stable_err); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL toggle_done_count got %0d want 1", done_cyc.size()); end
        for (int k = 0; k < hs_pix.size() && k < 140; k++) begin
            checks++;
            if (hs_pix[k] !== exp_pixel(dig, k)) begin
                errors++; $display("FAIL toggle_pix[%0d] got %h want %h", k, hs_pix[k], exp_pixel(dig, k));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            logic [14:0] dig;
            dig = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            capture(dig, 800, 2, 1 + int'($urandom_range(0, 3)), -1, '0, -1);
            checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL rand%0d_count got %0d want 140", t, hs_pix.size()); end
            checks++; if (stable_err != 0) begin errors++; $display("FAIL rand%0d_stable got %0d want 0", t, stable_err); end
            checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL rand%0d_done got %0d want 1", t, done_cyc.size()); end
            for (int k = 0; k < hs_pix.size() && k < 140; k++) begin
                checks++;
                if (hs_pix[k] !== exp_pixel(dig, k)) begin
                    errors++; $display("FAIL rand%0d_pix[%0d] dig=%h got %h want %h", t, k, dig, hs_pix[k], exp_pixel(dig, k));
                end
            end
        end
    endtask

    task automatic test_held_start();
        capture({3'd4, 4'd8, 4'd0, 4'd7}, 520, 0, 500, -1, '0, -1);
        checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL held_count got %0d want 140", hs_pix.size()); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL held_done got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] dig1 = {3'd1, 4'd2, 4'd3, 4'd4};
        logic [14:0] dig2 = {3'd0, 4'd0, 4'd9, 4'd9};
        capture(dig1, 300, 0, 1, 50, dig2, -1);
        checks++; if (hs_pix.size() != 280) begin errors++; $display("FAIL b2b_count got %0d want 280", hs_pix.size()); end
        for (int k = 0; k < hs_pix.size() && k < 280; k++) begin
            logic [17:0] e;
            e = (k < 140) ? exp_pixel(dig1, k) : exp_pixel(dig2, k - 140);
            checks++;
            if (hs_pix[k] !== e) begin errors++; $display("FAIL b2b_pix[%0d] got %h want %h", k, hs_pix[k], e); end
        end
        checks++; if (done_cyc.size() != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cyc.size()); end
        else begin
            checks++; if (done_cyc[0] != 142) begin errors++; $display("FAIL b2b_done0 got %0d want 142", done_cyc[0]); end
            checks++; if (done_cyc[1] != 284) begin errors++; $display("FAIL b2b_done1 got %0d want 284", done_cyc[1]); end
            if (hs_cyc.size() > 140) begin
                checks++; if (hs_cyc[140] != done_cyc[0] + 2) begin
                    errors++; $display("FAIL b2b_restart got %0d want %0d", hs_cyc[140], done_cyc[0] + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] dig1 = {3'd3, 4'd1, 4'd4, 4'd1};
        logic [14:0] dig2 = {3'd0, 4'd5, 4'd6, 4'd8};
        capture(dig1, 200, 0, 1, -1, '0, 70);
        checks++; if (!rst_seen) begin errors++; $display("FAIL rstmid_reached got 0 want 1"); end
        else begin
            checks++; if ({rst_plot, rst_busy, rst_done} !== 3'b000) begin
                errors++; $display("FAIL rstmid_outputs got plot=%b busy=%b done=%b want 0 0 0", rst_plot, rst_busy, rst_done);
            end
        end
        checks++; if (hs_pix.size() != 70) begin errors++; $display("FAIL rstmid_count got %0d want 70", hs_pix.size()); end
        checks++; if (done_cyc.size() != 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cyc.size()); end
        capture(dig2, 160, 0, 1, -1, '0, -1);
        checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL rstafter_count got %0d want 140", hs_pix.size()); end
        for (int k = 0; k < hs_pix.size() && k < 140; k++) begin
            checks++;
            if (hs_pix[k] !== exp_pixel(dig2, k)) begin
                errors++; $display("FAIL rstafter_pix[%0d] got %h want %h", k, hs_pix[k], exp_pixel(dig2, k));
            end
        end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != 142) begin
            errors++; $display("FAIL rstafter_done got %0d pulses want 1 at 142", done_cyc.size());
        end
    endtask

    task automatic test_blanking();
        logic [14:0] dig = {3'd0, 4'd0, 4'd4, 4'd2};
        logic [14:0] dig_c = {3'd1, 4'hC, 4'd3, 4'd4};
        int fg0, fg1;
        capture(dig, 160, 0, 1, -1, '0, -1);
        checks++; if (hs_pix.size() != 140) begin errors++; $display("FAIL lzb_count got %0d want 140", hs_pix.size()); end
        fg0 = 0;
        fg1 = 0;
        for (int k = 0; k < hs_pix.size() && k < 140; k++) begin
            checks++;
            if (hs_pix[k] !== exp_pixel(dig, k)) begin
                errors++; $display("FAIL lzb_pix[%0d] got %h want %h", k, hs_pix[k], exp_pixel(dig, k));
            end
            if (k < 35 && hs_pix[k][2:0] != BG) fg0++;
            if (k >= 35 && k < 70 && hs_pix[k][2:0] != BG) fg1++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (fg0 + fg1 != 0) begin errors++; $display("FAIL lzb_blank got %0d lit want 0", fg0 + fg1); end
`else
        checks++; if (fg0 == 0) begin errors++; $display("FAIL lzb_zero_glyph got 0 lit want nonzero"); end
`endif
        capture(dig_c, 160, 0, 1, -1, '0, -1);
        fg1 = 0;
        for (int k = 35; k < hs_pix.size() && k < 70; k++) if (hs_pix[k][2:0] != BG) fg1++;
        checks++; if (hs_pix.size() != 140 || fg1 != 0) begin
            errors++; $display("FAIL hunC_blank got %0d pixels %0d lit want 140 0", hs_pix.size(), fg1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_random();
        test_held_start();
        test_back_to_back();
        test_reset_mid();
        test_blanking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
